// File: rtl/serial_subtractor.sv
// Bit-serial X - Y, LSB first, through one full-adder cell
// with Y inverted and the carry seeded to 1.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             borrowOut,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0] xReg, yReg, zReg;
  logic [CW-1:0]    bitCount;
  logic             carry;
  logic             yInv, sBit, cNext, lastBit;

  assign yInv    = ~yReg[0];
  assign sBit    = xReg[0] ^ yInv ^ carry;
  assign cNext   = (xReg[0] & yInv)
                 | (xReg[0] & carry)
                 | (yInv & carry);
  assign lastBit = (bitCount == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // next-state decode; start is only honoured in IDLE
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = SHIFT;
      SHIFT:   if (lastBit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // operand capture, one bit per edge, result/flags latched on the MSB
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      xReg      <= '0;
      yReg      <= '0;
      zReg      <= '0;
      carry     <= 1'b0;
      bitCount  <= '0;
      Z         <= '0;
      borrowOut <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xReg     <= X;
            yReg     <= Y;
            carry    <= 1'b1;
            bitCount <= '0;
          end
        end
        SHIFT: begin
          zReg     <= {sBit, zReg[WIDTH-1:1]};
          xReg     <= {1'b0, xReg[WIDTH-1:1]};
          yReg     <= {1'b0, yReg[WIDTH-1:1]};
          carry    <= cNext;
          bitCount <= bitCount + CW'(1);
          if (lastBit) begin
            Z         <= {sBit, zReg[WIDTH-1:1]};
            overflow  <= carry ^ cNext;
            borrowOut <= ~cNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor
// (vector table plus multi-cycle corner sequences).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] X, Y;
  logic [W-1:0] Z;
  logic         borrowOut, overflow, busy, done;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .start(start),
    .X(X),
    .Y(Y),
    .Z(Z),
    .borrowOut(borrowOut),
    .overflow(overflow),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic         b;
    logic         o;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge
  // after the return to IDLE, so another op may start right away.
  task automatic runOp(input string nm,
                       input logic [W-1:0] x, y, ez,
                       input logic eb, eo);
    int cyc;
    int busyBad;
    X = x;
    Y = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busyBad = 0;
    if (!busy) busyBad++;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!busy) busyBad++;
    end
    check({nm, " latency"}, cyc, 8);
    check({nm, " busy"}, busyBad, 0);
    check({nm, " Z"}, Z, ez);
    check({nm, " flags"}, {borrowOut, overflow}, {eb, eo});
    @(negedge clk);
    check({nm, " idle"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int doneCnt;
    int busyBad;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    X = '0;
    Y = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset idle %0d", i),
            {Z, borrowOut, overflow, busy, done}, 12'h000);
    end

    // vector table
    for (int i = 0; i < 8; i++)
      runOp($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
            vecs[i].z, vecs[i].b, vecs[i].o);

    // extra starts during SHIFT and DONE are ignored
    X = 8'h10;
    Y = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    busyBad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        X = 8'hFF;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (!busy) busyBad++;
      if (done) doneCnt++;
    end
    check("ignore done at edge 8", done, 1'b1);
    check("ignore Z", Z, 8'h0F);
    X = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore busy continuous", busyBad, 0);
    check("ignore back idle", {busy, done}, 2'b00);
    @(negedge clk);
    check("ignore not queued", busy, 1'b0);
    check("ignore single done", doneCnt, 1);
    check("ignore Z held", Z, 8'h0F);

    // reset aborts an operation mid-SHIFT
    X = 8'h55;
    Y = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort outputs", {Z, borrowOut, overflow, done}, 11'h000);
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    check("abort no done", doneCnt, 0);
    runOp("after abort", 8'h55, 8'h22, 8'h33, 1'b0, 1'b0);

    // start held high: a new op every WIDTH+2 cycles
    X = 8'h09;
    Y = 8'h04;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("cont done %0d", i), done, (i % 10) == 8);
      if (done) check($sformatf("cont Z %0d", i), Z, 8'h05);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("cont final idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
